// File: rtl/mat_job_ctrl.sv
// Matrix-multiply job controller: parses A/B operand packets from a UART byte stream and returns the product bytes.
// Optional build macro CHECKSUM_EN adds a trailing checksum byte that must match the packet sum.
module mat_job_ctrl #(
    parameter int unsigned N      = 2,
    parameter logic [7:0]  OPCODE = 8'hFF,
    parameter int unsigned LAT    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_byte,
    input  logic               rx_valid,
    output logic [7:0]         tx_byte,
    output logic               tx_send,
    input  logic               tx_busy,
    output logic [8*N*N-1:0]   mat_a,
    output logic [8*N*N-1:0]   mat_b,
    input  logic [8*N*N-1:0]   mat_c,
    output logic               job_done,
    output logic               err
);

    localparam int unsigned NN = N * N;
    localparam int unsigned IW = $clog2(NN);
    localparam int unsigned CW = $clog2(NN + 1);
    localparam int unsigned WW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        JOB,
        DATA,
        CSUM,
        WAIT,
        SEND
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 job_open;
    logic [7:0]           job_id;
    logic                 sel_b;
    logic [CW-1:0]        cnt;
    logic [WW-1:0]        wait_cnt;
    logic [NN-1:0][7:0]   shadow;
    logic [NN-1:0][7:0]   shadow_upd;
    logic [NN-1:0][7:0]   a_q;
    logic [NN-1:0][7:0]   b_q;
    logic [NN-1:0][7:0]   c_buf;
    logic [7:0]           tx_byte_q;
    logic                 tx_send_q;
    logic                 job_done_q;
    logic                 err_q;
`ifdef CHECKSUM_EN
    logic [7:0]           sum;
`endif

    logic                 err_nxt;
    logic                 done_nxt;
    logic                 send_nxt;
    logic [7:0]           byte_nxt;
    logic                 open_job;
    logic                 close_job;
    logic                 commit;
    logic                 store_elem;
    logic                 latch_c;

    assign tx_byte  = tx_byte_q;
    assign tx_send  = tx_send_q;
    assign job_done = job_done_q;
    assign err      = err_q;
    assign mat_a    = a_q;
    assign mat_b    = b_q;

    // Next-state and per-cycle control strobes
    always_comb begin
        state_next = state;
        err_nxt    = 1'b0;
        done_nxt   = 1'b0;
        send_nxt   = 1'b0;
        byte_nxt   = tx_byte_q;
        open_job   = 1'b0;
        close_job  = 1'b0;
        commit     = 1'b0;
        store_elem = 1'b0;
        latch_c    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_valid && rx_byte == OPCODE) state_next = SEL;
            end
            SEL: begin
                if (rx_valid) begin
                    if (rx_byte == {7'd0, job_open}) begin
                        state_next = JOB;
                    end else begin
                        err_nxt    = 1'b1;
                        close_job  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            JOB: begin
                if (rx_valid) begin
                    if (!sel_b) begin
                        open_job   = 1'b1;
                        state_next = DATA;
                    end else if (rx_byte == job_id) begin
                        state_next = DATA;
                    end else begin
                        err_nxt    = 1'b1;
                        close_job  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    store_elem = 1'b1;
                    if (cnt == CW'(NN - 1)) begin
`ifdef CHECKSUM_EN
                        state_next = CSUM;
`else
                        commit     = 1'b1;
                        state_next = sel_b ? WAIT : IDLE;
`endif
                    end
                end
            end
            CSUM: begin
`ifdef CHECKSUM_EN
                if (rx_valid) begin
                    if (rx_byte == sum) begin
                        commit     = 1'b1;
                        state_next = sel_b ? WAIT : IDLE;
                    end else begin
                        err_nxt    = 1'b1;
                        close_job  = 1'b1;
                        state_next = IDLE;
                    end
                end
`else
                state_next = IDLE;
`endif
            end
            WAIT: begin
                if (wait_cnt == WW'(LAT - 1)) begin
                    latch_c    = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                // Leave a gap cycle after every request so the transmitter can raise busy
                if (!tx_busy && !tx_send_q) begin
                    send_nxt = 1'b1;
                    byte_nxt = (cnt == '0) ? job_id : c_buf[IW'(cnt - CW'(1))];
                    if (cnt == CW'(NN)) begin
                        done_nxt   = 1'b1;
                        close_job  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shadow buffer with the current element merged in, so the last element can commit directly
    always_comb begin
        shadow_upd = shadow;
        if (store_elem) shadow_upd[IW'(cnt)] = rx_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            job_open   <= 1'b0;
            job_id     <= '0;
            sel_b      <= 1'b0;
            cnt        <= '0;
            wait_cnt   <= '0;
            shadow     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_buf      <= '0;
            tx_byte_q  <= '0;
            tx_send_q  <= 1'b0;
            job_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_next;
            tx_byte_q  <= byte_nxt;
            tx_send_q  <= send_nxt;
            job_done_q <= done_nxt;
            err_q      <= err_nxt;
            shadow     <= shadow_upd;

            if (open_job) begin
                job_open <= 1'b1;
                job_id   <= rx_byte;
            end
            if (close_job) job_open <= 1'b0;

            if (state == SEL && rx_valid) sel_b <= rx_byte[0];

            if (commit) begin
                if (sel_b) b_q <= shadow_upd;
                else       a_q <= shadow_upd;
            end

            if (latch_c) c_buf <= mat_c;

            if (state_next == IDLE || latch_c) cnt <= '0;
            else if (store_elem || send_nxt)   cnt <= cnt + CW'(1);

            if (state == WAIT) wait_cnt <= wait_cnt + WW'(1);
            else               wait_cnt <= '0;
        end
    end

`ifdef CHECKSUM_EN
    // Running sum of matsel, job ID and elements
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (rx_valid) begin
            if (state == SEL)                        sum <= rx_byte;
            else if (state == JOB || state == DATA)  sum <= sum + rx_byte;
        end
    end
`endif

endmodule

// File: tb/tb_mat_job_ctrl.sv
// Self-checking bench for mat_job_ctrl (N=2): packet vector table plus busy-stall and mid-SEND reset sequences.
module tb_mat_job_ctrl;

    localparam int unsigned N  = 2;
    localparam int unsigned NN = N * N;
    localparam logic [7:0]  OPC = 8'hFF;

    logic            clk;
    logic            rst_n;
    logic [7:0]      rx_byte;
    logic            rx_valid;
    logic [7:0]      tx_byte;
    logic            tx_send;
    logic            tx_busy;
    logic [8*NN-1:0] mat_a;
    logic [8*NN-1:0] mat_b;
    logic [8*NN-1:0] mat_c;
    logic            job_done;
    logic            err;

    mat_job_ctrl #(.N(N), .OPCODE(OPC), .LAT(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .tx_byte  (tx_byte),
        .tx_send  (tx_send),
        .tx_busy  (tx_busy),
        .mat_a    (mat_a),
        .mat_b    (mat_b),
        .mat_c    (mat_c),
        .job_done (job_done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: 8-bit wrapping matrix product
    function automatic logic [8*NN-1:0] mm(input logic [8*NN-1:0] a, input logic [8*NN-1:0] b);
        logic [8*NN-1:0] c;
        logic [7:0]      acc;
        c = '0;
        for (int r = 0; r < N; r++) begin
            for (int cc = 0; cc < N; cc++) begin
                acc = 8'h00;
                for (int k = 0; k < N; k++)
                    acc = 8'(acc + 8'(a[8*(r*N+k) +: 8] * b[8*(k*N+cc) +: 8]));
                c[8*(r*N+cc) +: 8] = acc;
            end
        end
        return c;
    endfunction

    assign mat_c = mm(mat_a, mat_b);

    // Transmitter model and output monitor
    logic      busy_force;
    int        busy_cnt;
    logic      prev_send;
    logic      prev_busy;
    int        viol;
    int        done_cnt;
    int        err_cnt;
    logic [7:0] tx_q[$];

    assign tx_busy = busy_force || (busy_cnt != 0);

    always @(posedge clk) begin
        if (tx_send) begin
            tx_q.push_back(tx_byte);
            busy_cnt <= 2;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (tx_send && (prev_send || prev_busy)) viol++;
        if (job_done) done_cnt++;
        if (err) err_cnt++;
        prev_send <= tx_send;
        prev_busy <= tx_busy;
    end

    int total;
    int bad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic send_pkt(input logic [7:0] sel, input logic [7:0] id,
                            input logic [31:0] el, input logic [7:0] adj);
`ifdef CHECKSUM_EN
        logic [7:0] s;
        s = 8'(sel + id);
`endif
        send_byte(OPC);
        send_byte(sel);
        send_byte(id);
        for (int k = 0; k < 4; k++) begin
            send_byte(el[8*k +: 8]);
`ifdef CHECKSUM_EN
            s = 8'(s + el[8*k +: 8]);
`endif
        end
`ifdef CHECKSUM_EN
        send_byte(8'(s + adj));
`else
        if (adj != 8'h00) send_byte(8'h00);
`endif
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [39:0] pack_tx();
        logic [39:0] v;
        v = '0;
        for (int i = 0; i < tx_q.size() && i < 5; i++) v[8*i +: 8] = tx_q[i];
        return v;
    endfunction

    typedef struct {
        string       name;
        logic [7:0]  sel;
        logic [7:0]  id;
        logic [31:0] elems;
        logic [7:0]  cs_adj;
        int          exp_err;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        int          exp_ntx;
        logic [39:0] exp_tx;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int e0;
        int d0;
        int found;
        total      = 0;
        bad        = 0;
        viol       = 0;
        done_cnt   = 0;
        err_cnt    = 0;
        busy_force = 1'b0;
        busy_cnt   = 0;
        prev_send  = 1'b0;
        prev_busy  = 1'b0;
        rx_byte    = 8'h00;
        rx_valid   = 1'b0;
        rst_n      = 1'b0;

        vecs.push_back('{"a_07",       8'h00, 8'h07, 32'h04030201, 8'h00, 0, 32'h04030201, 32'h00000000, 0, 40'h0});
        vecs.push_back('{"b_07",       8'h01, 8'h07, 32'h08070605, 8'h00, 0, 32'h04030201, 32'h08070605, 5, 40'h322B161307});
`ifdef CHECKSUM_EN
        vecs.push_back('{"a_bad_csum", 8'h00, 8'h07, 32'h04030201, 8'h01, 1, 32'h04030201, 32'h08070605, 0, 40'h0});
`endif
        vecs.push_back('{"a_07_again", 8'h00, 8'h07, 32'h04030201, 8'h00, 0, 32'h04030201, 32'h08070605, 0, 40'h0});
        vecs.push_back('{"b_bad_id",   8'h01, 8'h08, 32'h44332211, 8'h00, 1, 32'h04030201, 32'h08070605, 0, 40'h0});
        vecs.push_back('{"b_no_job",   8'h01, 8'h07, 32'h08070605, 8'h00, 1, 32'h04030201, 32'h08070605, 0, 40'h0});
        vecs.push_back('{"sel_2",      8'h02, 8'h00, 32'h00000000, 8'h00, 1, 32'h04030201, 32'h08070605, 0, 40'h0});
        vecs.push_back('{"a_03",       8'h00, 8'h03, 32'h0C0B0A09, 8'h00, 0, 32'h0C0B0A09, 32'h08070605, 0, 40'h0});
        vecs.push_back('{"b_03_ident", 8'h01, 8'h03, 32'h01000001, 8'h00, 0, 32'h0C0B0A09, 32'h01000001, 5, 40'h0C0B0A0903});
        vecs.push_back('{"a_fe_wrap",  8'h00, 8'hFE, 32'hFFFFFFFF, 8'h00, 0, 32'hFFFFFFFF, 32'h01000001, 0, 40'h0});
        vecs.push_back('{"b_fe_wrap",  8'h01, 8'hFE, 32'h02000002, 8'h00, 0, 32'hFFFFFFFF, 32'h02000002, 5, 40'hFEFEFEFEFE});

        // Reset values
        wait_cycles(3);
        chk("rst_tx_send",  64'(tx_send),  64'h0);
        chk("rst_tx_byte",  64'(tx_byte),  64'h0);
        chk("rst_mat_a",    64'(mat_a),    64'h0);
        chk("rst_mat_b",    64'(mat_b),    64'h0);
        chk("rst_job_done", 64'(job_done), 64'h0);
        chk("rst_err",      64'(err),      64'h0);
        rst_n = 1'b1;
        wait_cycles(2);

        foreach (vecs[i]) begin
            tx_q.delete();
            e0 = err_cnt;
            d0 = done_cnt;
            send_pkt(vecs[i].sel, vecs[i].id, vecs[i].elems, vecs[i].cs_adj);
            wait_cycles(40);
            chk({vecs[i].name, "_err"},   64'(err_cnt - e0),     64'(vecs[i].exp_err));
            chk({vecs[i].name, "_done"},  64'(done_cnt - d0),    64'((vecs[i].exp_ntx > 0) ? 1 : 0));
            chk({vecs[i].name, "_ntx"},   64'(tx_q.size()),      64'(vecs[i].exp_ntx));
            chk({vecs[i].name, "_bytes"}, 64'(pack_tx()),        64'(vecs[i].exp_tx));
            chk({vecs[i].name, "_mat_a"}, 64'(mat_a),            64'(vecs[i].exp_a));
            chk({vecs[i].name, "_mat_b"}, 64'(mat_b),            64'(vecs[i].exp_b));
        end

        // Transmitter held busy through SEND
        tx_q.delete();
        d0 = done_cnt;
        send_pkt(8'h00, 8'h07, 32'h04030201, 8'h00);
        busy_force = 1'b1;
        send_pkt(8'h01, 8'h07, 32'h08070605, 8'h00);
        wait_cycles(40);
        chk("busy_hold_ntx", 64'(tx_q.size()), 64'h0);
        busy_force = 1'b0;
        wait_cycles(40);
        chk("busy_rel_ntx",   64'(tx_q.size()),      64'd5);
        chk("busy_rel_bytes", 64'(pack_tx()),        64'h322B161307);
        chk("busy_rel_done",  64'(done_cnt - d0),    64'd1);

        // Reset asserted while the third result byte is being requested
        tx_q.delete();
        send_pkt(8'h00, 8'h07, 32'h04030201, 8'h00);
        send_pkt(8'h01, 8'h07, 32'h08070605, 8'h00);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (tx_send && tx_q.size() == 2) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("mid_send_reached", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_tx_send", 64'(tx_send), 64'h0);
        chk("abort_tx_byte", 64'(tx_byte), 64'h0);
        chk("abort_mat_a",   64'(mat_a),   64'h0);
        chk("abort_mat_b",   64'(mat_b),   64'h0);
        wait_cycles(3);
        rst_n = 1'b1;
        tx_q.delete();
        d0 = done_cnt;
        wait_cycles(2);
        send_byte(8'h55);
        send_byte(8'hAA);
        wait_cycles(20);
        chk("post_rst_quiet", 64'(tx_q.size()), 64'h0);
        send_pkt(8'h00, 8'h07, 32'h04030201, 8'h00);
        send_pkt(8'h01, 8'h07, 32'h08070605, 8'h00);
        wait_cycles(40);
        chk("post_rst_ntx",   64'(tx_q.size()),   64'd5);
        chk("post_rst_bytes", 64'(pack_tx()),     64'h322B161307);
        chk("post_rst_done",  64'(done_cnt - d0), 64'd1);

        chk("tx_spacing_viol", 64'(viol), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
